// File: rtl/ct_spsram_init_ctrl.sv
// Init FSM and address counter, plus the mux that hands the SRAM port either to the
// user or to the fill engine. busy is the state register itself.
module ct_spsram_init_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 11,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   user_req,
    input  logic                   user_we,
    input  logic [ADDR_WIDTH-1:0]  user_addr,
    input  logic [DATA_WIDTH-1:0]  user_wdata,
    input  logic [DATA_WIDTH-1:0]  user_be,
    input  logic                   init_req,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [DATA_WIDTH-1:0]  mem_be,
    output logic                   user_rd,
    output logic                   busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_e                 state;
    logic [ADDR_WIDTH-1:0]  cnt;

    // init_req is only looked at in IDLE, so a pulse during a fill is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state == ST_INIT);
    assign user_rd = !busy && user_req && !user_we;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = user_addr;
        mem_wdata = user_wdata;
        mem_be    = user_be;
        if (busy) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt;
            mem_wdata = INIT_VALUE;
            mem_be    = '1;
        end else begin
            mem_req = user_req;
            mem_we  = user_we;
        end
    end

endmodule

// File: rtl/tc_sram.sv
// Generic synchronous SRAM primitive: single port, one-cycle read latency, per-byte enables.
// Read data holds its value until the next read on that port.
module tc_sram #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 1,
    parameter int unsigned Latency   = 1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

    if (NumPorts != 1 || Latency != 1) begin : g_param_check
        $error("tc_sram: only NumPorts = 1 and Latency = 1 are implemented");
    end

    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] bit_mask;

    for (genvar b = 0; b < DataWidth; b++) begin : g_mask
        assign bit_mask[b] = be_i[0][b / ByteWidth];
    end

    always_ff @(posedge clk_i) begin
        if (req_i[0] && we_i[0]) begin
            mem[addr_i[0]] <= (mem[addr_i[0]] & ~bit_mask) | (wdata_i[0] & bit_mask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else if (req_i[0] && !we_i[0]) begin
            rdata_o[0] <= mem[addr_i[0]];
        end
    end

endmodule

// File: rtl/ct_spsram_init_wrap.sv
// Parametrised single-port SRAM with active-low CEN/GWEN/WEN, hardware fill after reset
// or on INIT_REQ, read-valid strobe and an optional output register.
module ct_spsram_init_wrap #(
    parameter int unsigned            ADDR_WIDTH = 11,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            WE_WIDTH   = 32,
    parameter bit                     OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CEN,
    input  logic                   GWEN,
    input  logic [WE_WIDTH-1:0]    WEN,
    input  logic [ADDR_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  D,
    input  logic                   INIT_REQ,
    output logic [DATA_WIDTH-1:0]  Q,
    output logic                   QVLD,
    output logic                   INIT_BUSY
);

    localparam int unsigned SLICE = DATA_WIDTH / WE_WIDTH;

    logic [DATA_WIDTH-1:0]  user_be;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  mem_be;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   user_rd;
    logic                   rd_vld;
    logic                   rst_n;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_be
        assign user_be[g] = ~WEN[g / SLICE];
    end

    assign rst_n = ~RST;

    ct_spsram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_ctrl (
        .clk        (CLK),
        .rst        (RST),
        .user_req   (~CEN),
        .user_we    (~GWEN),
        .user_addr  (A),
        .user_wdata (D),
        .user_be    (user_be),
        .init_req   (INIT_REQ),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .user_rd    (user_rd),
        .busy       (INIT_BUSY)
    );

    tc_sram #(
        .NumWords  (2 ** ADDR_WIDTH),
        .DataWidth (DATA_WIDTH),
        .ByteWidth (1),
        .NumPorts  (1),
        .Latency   (1)
    ) u_sram (
        .clk_i   (CLK),
        .rst_ni  (rst_n),
        .req_i   (mem_req),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .be_i    (mem_be),
        .rdata_o (mem_rdata)
    );

    // rd_vld marks the cycle in which the SRAM output carries an accepted user read
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= user_rd;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_r;
        logic                  qvld_r;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                q_r    <= '0;
                qvld_r <= 1'b0;
            end else begin
                qvld_r <= rd_vld;
                if (rd_vld) begin
                    q_r <= mem_rdata;
                end
            end
        end

        assign Q    = q_r;
        assign QVLD = qvld_r;
    end else begin : g_no_out_reg
        assign Q    = mem_rdata;
        assign QVLD = rd_vld;
    end

endmodule

// File: tb/tb_ct_spsram_init_wrap.sv
// Directed bench for ct_spsram_init_wrap: one instance without and one with the output
// register, both driven by the same stimulus.
module tb_ct_spsram_init_wrap;

    localparam int          AW = 11;
    localparam int          DW = 32;
    localparam int          WW = 32;
    localparam logic [31:0] IV = 32'hDEAD_BEEF;
    localparam int          FILL = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic          gwen = 1'b1;
    logic [WW-1:0] wen = '1;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    logic          init_req = 1'b0;

    logic [DW-1:0] q0, q1;
    logic          qvld0, qvld1, busy0, busy1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ct_spsram_init_wrap #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WE_WIDTH (WW), .OUT_REG (1'b0), .INIT_VALUE (IV)
    ) u_dut0 (
        .CLK (clk), .RST (rst), .CEN (cen), .GWEN (gwen), .WEN (wen), .A (a), .D (d),
        .INIT_REQ (init_req), .Q (q0), .QVLD (qvld0), .INIT_BUSY (busy0)
    );

    ct_spsram_init_wrap #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .WE_WIDTH (WW), .OUT_REG (1'b1), .INIT_VALUE (IV)
    ) u_dut1 (
        .CLK (clk), .RST (rst), .CEN (cen), .GWEN (gwen), .WEN (wen), .A (a), .D (d),
        .INIT_REQ (init_req), .Q (q1), .QVLD (qvld1), .INIT_BUSY (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue_read(input logic [AW-1:0] addr);
        cen  = 1'b0;
        gwen = 1'b1;
        a    = addr;
        tick();
        cen  = 1'b1;
    endtask

    task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [WW-1:0] mask_n);
        cen  = 1'b0;
        gwen = 1'b0;
        a    = addr;
        d    = data;
        wen  = mask_n;
        tick();
        cen  = 1'b1;
        gwen = 1'b1;
        wen  = '1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy0 && guard < 5000) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_reset();
        int t0;
        tick(); tick(); tick();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL reset_busy0: got %b want 1", busy0); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL reset_busy1: got %b want 1", busy1); end
        total++; if (qvld0 !== 1'b0) begin bad++; $display("FAIL reset_qvld0: got %b want 0", qvld0); end
        total++; if (qvld1 !== 1'b0) begin bad++; $display("FAIL reset_qvld1: got %b want 0", qvld1); end
        total++; if (q1 !== 32'h0) begin bad++; $display("FAIL reset_q1: got %h want 00000000", q1); end
        rst = 1'b0;
        t0 = cyc;
        wait_idle();
        total++; if (cyc - t0 !== FILL) begin bad++; $display("FAIL reset_fill_len: got %0d want %0d", cyc - t0, FILL); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1_end: got %b want 0", busy1); end
    endtask

    task automatic test_init_reads();
        logic [AW-1:0] addrs [3];
        addrs[0] = 11'h000;
        addrs[1] = 11'h3FF;
        addrs[2] = 11'h7FF;
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i]);
            total++; if (qvld0 !== 1'b1) begin bad++; $display("FAIL init_rd_qvld[%0d]: got %b want 1", i, qvld0); end
            total++; if (q0 !== IV) begin bad++; $display("FAIL init_rd_q[%0d]: got %h want %h", i, q0, IV); end
            tick();
            total++; if (qvld0 !== 1'b0) begin bad++; $display("FAIL init_rd_qvld_drop[%0d]: got %b want 0", i, qvld0); end
            total++; if (qvld1 !== 1'b1 || q1 !== IV) begin
                bad++; $display("FAIL init_rd_reg[%0d]: got qvld=%b q=%h want qvld=1 q=%h", i, qvld1, q1, IV);
            end
        end
    endtask

    task automatic test_masked_write();
        issue_write(11'd5, 32'h1234_5678, 32'h0000_FFFF);
        total++; if (qvld0 !== 1'b0) begin bad++; $display("FAIL wr_no_qvld: got %b want 0", qvld0); end
        total++; if (q0 !== IV) begin bad++; $display("FAIL wr_q_hold: got %h want %h", q0, IV); end
        issue_read(11'd5);
        total++; if (qvld0 !== 1'b1) begin bad++; $display("FAIL mask_rd_qvld: got %b want 1", qvld0); end
        total++; if (q0 !== 32'h1234_BEEF) begin bad++; $display("FAIL mask_rd_q: got %h want 1234beef", q0); end
        issue_write(11'd5, 32'h0000_0000, 32'hFFFF_FFFF);
        issue_read(11'd5);
        total++; if (q0 !== 32'h1234_BEEF) begin bad++; $display("FAIL noop_wr_q: got %h want 1234beef", q0); end
    endtask

    task automatic test_back_to_back();
        issue_write(11'd1, 32'h1111_1111, '0);
        issue_write(11'd2, 32'h2222_2222, '0);
        issue_write(11'd3, 32'h3333_3333, '0);
        cen = 1'b0; gwen = 1'b1; a = 11'd1;
        tick();
        total++; if (qvld0 !== 1'b1 || q0 !== 32'h1111_1111) begin bad++; $display("FAIL b2b_0a: got qvld=%b q=%h want 1/11111111", qvld0, q0); end
        total++; if (qvld1 !== 1'b0) begin bad++; $display("FAIL b2b_1a: got qvld=%b want 0", qvld1); end
        a = 11'd2;
        tick();
        total++; if (qvld0 !== 1'b1 || q0 !== 32'h2222_2222) begin bad++; $display("FAIL b2b_0b: got qvld=%b q=%h want 1/22222222", qvld0, q0); end
        total++; if (qvld1 !== 1'b1 || q1 !== 32'h1111_1111) begin bad++; $display("FAIL b2b_1b: got qvld=%b q=%h want 1/11111111", qvld1, q1); end
        a = 11'd3;
        tick();
        total++; if (qvld0 !== 1'b1 || q0 !== 32'h3333_3333) begin bad++; $display("FAIL b2b_0c: got qvld=%b q=%h want 1/33333333", qvld0, q0); end
        total++; if (qvld1 !== 1'b1 || q1 !== 32'h2222_2222) begin bad++; $display("FAIL b2b_1c: got qvld=%b q=%h want 1/22222222", qvld1, q1); end
        cen = 1'b1;
        tick();
        total++; if (qvld0 !== 1'b0 || q0 !== 32'h3333_3333) begin bad++; $display("FAIL b2b_0d: got qvld=%b q=%h want 0/33333333", qvld0, q0); end
        total++; if (qvld1 !== 1'b1 || q1 !== 32'h3333_3333) begin bad++; $display("FAIL b2b_1d: got qvld=%b q=%h want 1/33333333", qvld1, q1); end
        tick();
        total++; if (qvld1 !== 1'b0 || q1 !== 32'h3333_3333) begin bad++; $display("FAIL b2b_1e: got qvld=%b q=%h want 0/33333333", qvld1, q1); end
    endtask

    task automatic test_init_req_read();
        int t0;
        init_req = 1'b1; cen = 1'b0; gwen = 1'b1; a = 11'd5;
        tick();
        init_req = 1'b0; cen = 1'b1;
        t0 = cyc;
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL ireq_busy: got %b want 1", busy0); end
        total++; if (qvld0 !== 1'b1 || q0 !== 32'h1234_BEEF) begin bad++; $display("FAIL ireq_rd: got qvld=%b q=%h want 1/1234beef", qvld0, q0); end
        issue_read(11'd1);
        total++; if (qvld0 !== 1'b0) begin bad++; $display("FAIL busy_rd_qvld: got %b want 0", qvld0); end
        total++; if (q0 !== 32'h1234_BEEF) begin bad++; $display("FAIL busy_rd_q_hold: got %h want 1234beef", q0); end
        for (int i = 0; i < 20; i++) tick();
        issue_write(11'd7, 32'h0000_0000, '0);
        for (int i = 0; i < 600; i++) tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        wait_idle();
        total++; if (cyc - t0 !== FILL) begin bad++; $display("FAIL ireq_fill_len: got %0d want %0d", cyc - t0, FILL); end
        issue_read(11'd7);
        total++; if (q0 !== IV) begin bad++; $display("FAIL busy_wr_dropped: got %h want %h", q0, IV); end
        issue_read(11'd5);
        total++; if (q0 !== IV) begin bad++; $display("FAIL refill_addr5: got %h want %h", q0, IV); end
    endtask

    task automatic test_init_req_write();
        init_req = 1'b1; cen = 1'b0; gwen = 1'b0; a = 11'd9; d = 32'hA5A5_A5A5; wen = '0;
        tick();
        init_req = 1'b0; cen = 1'b1; gwen = 1'b1; wen = '1;
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL ireq_wr_busy: got %b want 1", busy0); end
        wait_idle();
        issue_read(11'd9);
        total++; if (qvld0 !== 1'b1 || q0 !== IV) begin bad++; $display("FAIL ireq_wr_addr9: got qvld=%b q=%h want 1/%h", qvld0, q0, IV); end
    endtask

    task automatic test_reset_mid_init();
        int t0;
        issue_write(11'd2000, 32'h1111_1111, '0);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy0); end
        rst = 1'b1;
        tick();
        total++; if (busy0 !== 1'b1 || qvld0 !== 1'b0) begin bad++; $display("FAIL mid_rst_state: got busy=%b qvld=%b want 1/0", busy0, qvld0); end
        rst = 1'b0;
        t0 = cyc;
        wait_idle();
        total++; if (cyc - t0 !== FILL) begin bad++; $display("FAIL mid_fill_len: got %0d want %0d", cyc - t0, FILL); end
        issue_read(11'd2000);
        total++; if (qvld0 !== 1'b1 || q0 !== IV) begin bad++; $display("FAIL mid_addr2000: got qvld=%b q=%h want 1/%h", qvld0, q0, IV); end
    endtask

    initial begin
        test_reset();
        test_init_reads();
        test_masked_write();
        test_back_to_back();
        test_init_req_read();
        test_init_req_write();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
